// File: rtl/red_pitaya_asg_sweep_if.sv
// Sweep controller bundle: quasi-static sweep configuration, start/abort
// controls and the registered step/status outputs of one ASG channel.
interface red_pitaya_asg_sweep_if #(
  parameter int RSZ = 14,
  parameter int PW  = RSZ + 48
);
  logic [PW-1:0]    set_start_i;
  logic [PW-1:0]    set_stop_i;
  logic [PW-1:0]    set_inc_i;
  logic [31:0]      set_period_i;
  logic [1:0]       set_mode_i;
  logic             set_trig_en_i;
  logic             sweep_start_i;
  logic             trig_i;
  logic             abort_i;
  logic [RSZ+15:0]  step_hi_o;
  logic [31:0]      step_lo_o;
  logic             busy_o;
  logic             dir_o;
  logic             done_o;

  modport master (
    output set_start_i, set_stop_i, set_inc_i,
    output set_period_i, set_mode_i, set_trig_en_i,
    output sweep_start_i, trig_i, abort_i,
    input  step_hi_o, step_lo_o, busy_o, dir_o, done_o
  );

  modport slave (
    input  set_start_i, set_stop_i, set_inc_i,
    input  set_period_i, set_mode_i, set_trig_en_i,
    input  sweep_start_i, trig_i, abort_i,
    output step_hi_o, step_lo_o, busy_o, dir_o, done_o
  );
endinterface

// File: rtl/red_pitaya_asg_sweep.sv
// Linear chirp generator feeding an ASG channel phase step (once/saw/tri).
// Ports: dac_clk_i, dac_rstn_i (async, active-low), sw (sweep bundle, slave).
module red_pitaya_asg_sweep #(
  parameter int RSZ = 14,
  parameter int PW  = RSZ + 48
) (
  input  logic                    dac_clk_i,
  input  logic                    dac_rstn_i,
  red_pitaya_asg_sweep_if.slave   sw
);

  typedef enum logic [1:0] {
    IDLE,
    UP,
    DN,
    HOLD
  } state_t;

  state_t         st_q, st_d;
  logic [PW-1:0]  step_q, step_d;
  logic [31:0]    cnt_q, cnt_d;
  logic           dir_q, dir_d;
  logic           done_q, done_d;
  logic           busy_q, busy_d;

  logic           start_ev;
  logic           tick;
  logic           is_saw;
  logic           is_tri;
  logic           is_once;
  logic [31:0]    reload;
  logic [PW-1:0]  start;
  logic [PW-1:0]  stop;
  logic [PW-1:0]  inc;

  // Sums/differences are formed one bit wider so nothing ever wraps.
  function automatic logic [PW-1:0] add_min(
    input logic [PW-1:0] a,
    input logic [PW-1:0] b,
    input logic [PW-1:0] hi
  );
    logic [PW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return (s > {1'b0, hi}) ? hi : s[PW-1:0];
  endfunction

  function automatic logic [PW-1:0] sub_max(
    input logic [PW-1:0] a,
    input logic [PW-1:0] b,
    input logic [PW-1:0] lo
  );
    logic [PW:0] d;
    d = {1'b0, a} - {1'b0, b};
    return (d[PW] || (d[PW-1:0] < lo)) ? lo : d[PW-1:0];
  endfunction

  assign start    = sw.set_start_i;
  assign stop     = sw.set_stop_i;
  assign inc      = sw.set_inc_i;
  assign start_ev = sw.sweep_start_i |
                    (sw.trig_i & sw.set_trig_en_i);
  assign reload   = (sw.set_period_i == 32'd0) ?
                    32'd0 : sw.set_period_i - 32'd1;
  assign tick     = (cnt_q == 32'd0);
  assign is_saw   = (sw.set_mode_i == 2'd1);
  assign is_tri   = (sw.set_mode_i == 2'd2);
  assign is_once  = !is_saw && !is_tri;

  always_ff @(posedge dac_clk_i or negedge dac_rstn_i) begin
    if (!dac_rstn_i) begin
      st_q   <= IDLE;
      step_q <= '0;
      cnt_q  <= '0;
      dir_q  <= 1'b0;
      done_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      st_q   <= st_d;
      step_q <= step_d;
      cnt_q  <= cnt_d;
      dir_q  <= dir_d;
      done_q <= done_d;
      busy_q <= busy_d;
    end
  end

  always_comb begin
    st_d   = st_q;
    step_d = step_q;
    cnt_d  = cnt_q;
    dir_d  = dir_q;
    done_d = 1'b0;
    if (sw.abort_i) begin
      st_d   = IDLE;
      dir_d  = 1'b0;
      step_d = start;
    end else if (start_ev) begin
      step_d = start;
      cnt_d  = reload;
      if (start >= stop) begin
        st_d   = HOLD;
        done_d = 1'b1;
      end else begin
        st_d  = UP;
        dir_d = 1'b0;
      end
    end else begin
      unique case (st_q)
        IDLE: step_d = start;
        UP: begin
          if (!tick) begin
            cnt_d = cnt_q - 32'd1;
          end else begin
            cnt_d = reload;
            if (step_q == stop) begin
              unique case (1'b1)
                is_once: begin
                  st_d   = HOLD;
                  done_d = 1'b1;
                end
                is_saw: begin
                  step_d = start;
                  done_d = 1'b1;
                end
                is_tri: begin
                  st_d   = DN;
                  dir_d  = 1'b1;
                  step_d = sub_max(stop, inc, start);
                end
              endcase
            end else begin
              step_d = add_min(step_q, inc, stop);
            end
          end
        end
        DN: begin
          if (!tick) begin
            cnt_d = cnt_q - 32'd1;
          end else begin
            cnt_d = reload;
            if (step_q == start) begin
              st_d   = UP;
              dir_d  = 1'b0;
              step_d = add_min(start, inc, stop);
              done_d = 1'b1;
            end else begin
              step_d = sub_max(step_q, inc, start);
            end
          end
        end
        HOLD: begin
        end
        default: st_d = IDLE;
      endcase
    end
    busy_d = (st_d == UP) || (st_d == DN);
  end

  assign sw.step_hi_o = step_q[PW-1:32];
  assign sw.step_lo_o = step_q[31:0];
  assign sw.busy_o    = busy_q;
  assign sw.dir_o     = dir_q;
  assign sw.done_o    = done_q;

endmodule
